// File: rtl/reg_file_dump.sv
// reg_file_dump: sequential debug reader for the LEGv8 register file.
// A start pulse walks every register through both asynchronous read ports,
// one even/odd pair per fetch. Each value is then streamed with its index
// over a valid/ready output.
module reg_file_dump #(
    parameter int WORD = 64,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [4:0]      rd_reg1,
    output logic [4:0]      rd_reg2,
    input  logic [WORD-1:0] rd_data1,
    input  logic [WORD-1:0] rd_data2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_idx,
    output logic [WORD-1:0] out_data
);

    // Width of the pair counter. For NREG == 2 the counter degenerates,
    // because it never leaves zero, so keep it at least one bit wide.
    localparam int            PW        = (NREG > 2) ? $clog2(NREG) - 1 : 1;
    localparam logic [PW-1:0] LAST_PAIR = PW'(NREG / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND0,
        S_SEND1,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   pair;
    logic [PW-1:0]   pair_nx;
    logic [WORD-1:0] buf0;
    logic [WORD-1:0] buf1;
    logic [4:0]      pair_base;

    // Even register number of the current pair; the odd one is base + 1.
    assign pair_base = 5'({pair, 1'b0});

    // State and pair counter register; rst wins over everything, including start.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pair  <= '0;
        end else begin
            state <= state_nx;
            pair  <= pair_nx;
        end
    end

    // Next-state and pair-advance logic. out_ready only matters in the SEND states.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        pair_nx  = pair;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pair_nx  = '0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nx = S_SEND0;
            end
            S_SEND0: begin
                if (out_ready) begin
                    state_nx = S_SEND1;
                end
            end
            S_SEND1: begin
                if (out_ready) begin
                    if (pair == LAST_PAIR) begin
                        state_nx = S_DONE;
                    end else begin
                        pair_nx  = pair + PW'(1);
                        state_nx = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Snapshot both read ports at the end of the FETCH cycle. Later
    // reg_file writes to this pair are therefore not seen.
    // NOTE: these are two plain holding registers, not a memory array.
    // Resetting them is cheap and keeps out_data at zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (state == S_FETCH) begin
            buf0 <= rd_data1;
            buf1 <= rd_data2;
        end
    end

    // Moore outputs decoded from state. out_idx and out_data depend only on
    // registered values, so they hold steady while the consumer stalls.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        out_valid = (state == S_SEND0) || (state == S_SEND1);
        rd_reg1   = pair_base;
        rd_reg2   = pair_base | 5'd1;
        out_idx   = (state == S_SEND1) ? (pair_base | 5'd1) : pair_base;
        out_data  = (state == S_SEND1) ? buf1 : buf0;
    end

endmodule

// File: tb/tb_reg_file_dump.sv
// Testbench for reg_file_dump. A behavioural register-file array drives the
// read ports. A cycle-level model of the dump protocol predicts every output.
module tb_reg_file_dump;

    localparam int WORD = 64;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            busy;
    logic            done;
    logic [4:0]      rd_reg1;
    logic [4:0]      rd_reg2;
    logic [WORD-1:0] rd_data1;
    logic [WORD-1:0] rd_data2;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_idx;
    logic [WORD-1:0] out_data;

    logic [WORD-1:0] regs [NREG];

    int vectors     = 0;
    int miscompares = 0;

    // Asynchronous read ports of the register file.
    assign rd_data1 = regs[rd_reg1];
    assign rd_data2 = regs[rd_reg2];

    always #5 clk = ~clk;

    reg_file_dump #(.WORD(WORD), .NREG(NREG)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_reg1   (rd_reg1),
        .rd_reg2   (rd_reg2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_data  (out_data)
    );

    task automatic preload_identity();
        for (int k = 0; k < NREG; k++) regs[k] = 64'(k);
    endtask

    // Run one full dump, starting from a negedge in an IDLE cycle.
    // mode: 0 = ready always 1, 1 = ready pattern 1,0,0,..., 2 = random ready.
    // The model tracks which beat is outstanding. It snapshots the register
    // file in the model's FETCH cycle and predicts each cycle's outputs.
    task automatic run_dump(input int mode, input bit spam, input bit wr11, input bit keep_start);
        logic [WORD-1:0] snap [NREG];
        int   beat;
        int   phase;   // 1 = fetch, 2 = beat offered, 3 = done pulse, 0 = finished
        int   c;
        int   k;
        bit   r;
        logic exp_valid;
        logic exp_done;
        beat  = 0;
        phase = 1;
        c     = 1;
        k     = 0;
        start = 1'b1;
        @(negedge clk);
        while (phase != 0 && c < 3000) begin
            start = spam ? 1'($urandom) : 1'b0;
            if (mode == 0)      r = 1'b1;
            else if (mode == 1) r = (k % 3 == 0);
            else                r = ($urandom % 4 != 0);
            exp_valid = (phase == 2);
            exp_done  = (phase == 3);
            vectors++;
            if ({out_valid, busy, done} !== {exp_valid, 1'b1, exp_done}) begin
                miscompares++;
                $display("FAIL ctrl cycle %0d: got valid/busy/done=%b%b%b expected %b1%b",
                         c, out_valid, busy, done, exp_valid, exp_done);
            end
            case (phase)
                1: begin
                    vectors++;
                    if (rd_reg1 !== 5'(beat) || rd_reg2 !== 5'(beat + 1)) begin
                        miscompares++;
                        $display("FAIL rd_addr cycle %0d: got %0d/%0d expected %0d/%0d",
                                 c, rd_reg1, rd_reg2, beat, beat + 1);
                    end
                    snap[beat]     = regs[beat];
                    snap[beat + 1] = regs[beat + 1];
                    phase = 2;
                end
                2: begin
                    vectors++;
                    if (out_idx !== 5'(beat) || out_data !== snap[beat]) begin
                        miscompares++;
                        $display("FAIL beat cycle %0d: got idx %0d data %0h expected idx %0d data %0h",
                                 c, out_idx, out_data, beat, snap[beat]);
                    end
                    if (wr11 && beat == 10) regs[11] = 64'd100;
                    if (r) begin
                        beat++;
                        if (beat % 2 == 0) phase = (beat == NREG) ? 3 : 1;
                    end
                    k++;
                end
                3: begin
                    if (keep_start) start = 1'b1;
                    phase = 0;
                end
                default: phase = 0;
            endcase
            out_ready = r;
            @(negedge clk);
            c++;
        end
        if (phase != 0) begin
            miscompares++;
            $display("FAIL timeout: dump model stuck in phase %0d at beat %0d", phase, beat);
        end
        out_ready = 1'b0;
        vectors++;
        if ({out_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_after: got valid/busy/done=%b%b%b expected 000", out_valid, busy, done);
        end
        start = keep_start;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        preload_identity();
        repeat (3) @(negedge clk);
        vectors++;
        if ({out_valid, busy, done} !== 3'b000 || out_idx !== 5'd0 || out_data !== '0
            || rd_reg1 !== 5'd0 || rd_reg2 !== 5'd1) begin
            miscompares++;
            $display("FAIL reset: got v/b/d=%b%b%b idx %0d data %0h rd %0d/%0d expected 000 0 0 0/1",
                     out_valid, busy, done, out_idx, out_data, rd_reg1, rd_reg2);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        preload_identity();
        run_dump(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        preload_identity();
        run_dump(1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_snapshot();
        preload_identity();
        run_dump(0, 1'b0, 1'b1, 1'b0);
        run_dump(0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (regs[11] !== 64'd100) begin
            miscompares++;
            $display("FAIL x11_write: got %0d expected 100", regs[11]);
        end
    endtask

    task automatic test_x1();
        preload_identity();
        regs[1] = 64'd123456789;
        run_dump(2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        preload_identity();
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 5'd16) begin
            miscompares++;
            $display("FAIL mid_pre: got valid %b idx %0d expected 1 16", out_valid, out_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({out_valid, busy, done} !== 3'b000 || rd_reg1 !== 5'd0 || rd_reg2 !== 5'd1
            || out_idx !== 5'd0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got v/b/d=%b%b%b rd %0d/%0d idx %0d expected 000 0/1 0",
                     out_valid, busy, done, rd_reg1, rd_reg2, out_idx);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL no_done %0d: got done %b busy %b expected 0 0", i, done, busy);
            end
        end
        run_dump(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_start_spam();
        preload_identity();
        run_dump(0, 1'b1, 1'b0, 1'b1);
        run_dump(0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < NREG; k++) regs[k] = {$urandom, $urandom};
            run_dump(2, n[0], 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_x1();
        test_reset_mid();
        test_start_spam();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
